parity_decoder_stream: RTL

- Parametrised successor to the 9-bit parity checker.
- Accepts DATA_W data bits plus one parity bit over a valid/ready handshake and checks even or odd parity.
- Forwards good words, or optionally all words tagged with an error flag, through a one-entry registered output stage.
- Keeps a sticky error flag plus saturating error and word counters for status readout; sits between the transceiver's deserialiser and the byte sink.

---
 rtl/parity_decoder_stream.sv | 90 +++++++++
 1 files changed

// File: rtl/parity_decoder_stream.sv
// Parity checker on a valid/ready stream: checks even/odd parity of DATA_W+1 bits,
// forwards (or drops) words through a one-entry output register, and keeps error/word status.
module parity_decoder_stream #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int DROP_BAD   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  input  logic              cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic             ODD     = (PARITY_ODD != 0);
  localparam logic             DROP    = (DROP_BAD != 0);

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_err_reg;
  logic              err_sticky_reg, err_sticky_next;
  logic [CNT_W-1:0]  err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next;
  logic [CNT_W-1:0]  err_base, word_base;

  logic acc;
  logic bad;
  logic load;

  // The output slot is free when empty or when its word leaves this cycle.
  assign in_ready = !out_valid_reg || out_ready;
  assign acc      = in_valid && in_ready;
  assign bad      = (^in_data) ^ ODD;
  assign load     = acc && (!bad || !DROP);

  // Clear takes effect first, so a word accepted alongside cnt_clr is still counted.
  always_comb begin
    err_base        = cnt_clr ? '0 : err_cnt_reg;
    word_base       = cnt_clr ? '0 : word_cnt_reg;
    err_cnt_next    = err_base;
    word_cnt_next   = word_base;
    err_sticky_next = (cnt_clr ? 1'b0 : err_sticky_reg) || (acc && bad);
    if (acc && (word_base != CNT_MAX)) begin
      word_cnt_next = word_base + CNT_W'(1);
    end
    if (acc && bad && (err_base != CNT_MAX)) begin
      err_cnt_next = err_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_err_reg    <= 1'b0;
      err_sticky_reg <= 1'b0;
      err_cnt_reg    <= '0;
      word_cnt_reg   <= '0;
    end else begin
      if (load) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data[DATA_W-1:0];
        out_err_reg   <= bad;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      err_sticky_reg <= err_sticky_next;
      err_cnt_reg    <= err_cnt_next;
      word_cnt_reg   <= word_cnt_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_err    = out_err_reg;
  assign err_sticky = err_sticky_reg;
  assign err_cnt    = err_cnt_reg;
  assign word_cnt   = word_cnt_reg;

endmodule
